// File: rtl/arriving_airlock_if.sv
// Door sensors, operator commands and status outputs of the arrival airlock.
// The controller takes the slave view; the environment takes the master view.
interface arriving_airlock_if;
    logic       tick;
    logic       innerPort;
    logic       outerPort;
    logic       arriving;
    logic       evac;
    logic       pressurize;
    logic [6:0] display;
    logic       outerUnlock;
    logic       innerUnlock;
    logic       busy;
    logic       fault;

    modport master (
        output tick, innerPort, outerPort, arriving, evac, pressurize,
        input  display, outerUnlock, innerUnlock, busy, fault
    );

    modport slave (
        input  tick, innerPort, outerPort, arriving, evac, pressurize,
        output display, outerUnlock, innerUnlock, busy, fault
    );
endinterface

// File: rtl/arriving_airlock.sv
// Moore controller that cycles an airlock for an arriving craft:
// announce, evacuate, dock, pressurize, let the crew through the inner door.
module arriving_airlock #(
    parameter int unsigned ANN_TICKS   = 1,
    parameter int unsigned EVAC_TICKS  = 2,
    parameter int unsigned PRESS_TICKS = 4
) (
    input logic               clock,
    input logic               rst,
    arriving_airlock_if.slave bus_io
);

    typedef enum logic [3:0] {
        StIdle, StAnnounce, StWaitEvac, StEvac, StOuterWait, StDocked,
        StWaitPress, StPress, StInnerWait, StInnerExit, StFault
    } state_e;

    localparam logic [2:0] AnnLast   = 3'(ANN_TICKS - 1);
    localparam logic [2:0] EvacLast  = 3'(EVAC_TICKS - 1);
    localparam logic [2:0] PressLast = 3'(PRESS_TICKS - 1);

    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegP     = 7'b0001100;
    localparam logic [6:0] SegF     = 7'b0001110;
    localparam logic [6:0] SegBlank = 7'b1111111;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic tick, in_open, out_open;
    logic timed, timer_done;

    assign tick     = bus_io.tick;
    assign in_open  = bus_io.innerPort;
    assign out_open = bus_io.outerPort;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        timed      = 1'b0;
        timer_done = 1'b0;
        unique case (state_q)
            StAnnounce: begin timed = 1'b1; timer_done = tick && (cnt_q == AnnLast);   end
            StEvac:     begin timed = 1'b1; timer_done = tick && (cnt_q == EvacLast);  end
            StPress:    begin timed = 1'b1; timer_done = tick && (cnt_q == PressLast); end
            default:    ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:
                if (bus_io.arriving && !in_open && !out_open) state_d = StAnnounce;
            StAnnounce:
                if (timer_done) state_d = StWaitEvac;
            StWaitEvac:
                if (bus_io.evac && !in_open && !out_open) state_d = StEvac;
            StEvac:
                if (in_open || out_open) state_d = StFault;
                else if (timer_done)     state_d = StOuterWait;
            StOuterWait:
                if (in_open)       state_d = StFault;
                else if (out_open) state_d = StDocked;
            StDocked:
                if (in_open)                              state_d = StFault;
                else if (!out_open && !bus_io.arriving)   state_d = StWaitPress;
            StWaitPress:
                if (in_open)                  state_d = StFault;
                else if (out_open)            state_d = StDocked;
                else if (bus_io.pressurize)   state_d = StPress;
            StPress:
                if (in_open || out_open) state_d = StFault;
                else if (timer_done)     state_d = StInnerWait;
            StInnerWait:
                if (in_open) state_d = StInnerExit;
            StInnerExit:
                if (!in_open) state_d = StIdle;
            StFault:
                state_d = StFault;
            default:
                state_d = StFault;
        endcase
    end

    // Any state change restarts the timer, so a tick on the entering edge is never counted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if (timed && tick) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    logic [6:0] display;
    logic       outer_unlock, inner_unlock, busy, fault;

    always_comb begin
        display      = SegBlank;
        outer_unlock = 1'b0;
        inner_unlock = 1'b0;
        busy         = (state_q != StIdle) && (state_q != StFault);
        fault        = (state_q == StFault);
        unique case (state_q)
            StAnnounce:            display = SegA;
            StEvac:                display = SegE;
            StPress:               display = SegP;
            StFault:               display = SegF;
            StOuterWait, StDocked: outer_unlock = 1'b1;
            StInnerWait, StInnerExit: inner_unlock = 1'b1;
            default:               ;
        endcase
    end

    assign bus_io.display     = display;
    assign bus_io.outerUnlock = outer_unlock;
    assign bus_io.innerUnlock = inner_unlock;
    assign bus_io.busy        = busy;
    assign bus_io.fault       = fault;

endmodule

// File: tb/tb_arriving_airlock.sv
// Randomized and directed stimulus for the airlock controller, checked by a queue-based
// scoreboard fed from a countdown-style reference model.
module tb_arriving_airlock;

    localparam int unsigned AnnN   = 1;
    localparam int unsigned EvacN  = 2;
    localparam int unsigned PressN = 4;

    typedef struct packed {
        logic [6:0] display;
        logic       ou;
        logic       iu;
        logic       busy;
        logic       fault;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    arriving_airlock_if bus ();

    arriving_airlock #(
        .ANN_TICKS  (AnnN),
        .EVAC_TICKS (EvacN),
        .PRESS_TICKS(PressN)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus_io(bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: named phases with a "ticks still to wait" countdown.
    string m_phase = "IDLE";
    int    m_left  = 0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t expected_of(input string ph);
        exp_t e;
        e.display = 7'b1111111;
        e.ou      = (ph == "OUTER_WAIT") || (ph == "DOCKED");
        e.iu      = (ph == "INNER_WAIT") || (ph == "INNER_EXIT");
        e.busy    = (ph != "IDLE") && (ph != "FAULT");
        e.fault   = (ph == "FAULT");
        if (ph == "ANNOUNCE") e.display = 7'b0001000;
        if (ph == "EVAC")     e.display = 7'b0000110;
        if (ph == "PRESS")    e.display = 7'b0001100;
        if (ph == "FAULT")    e.display = 7'b0001110;
        return e;
    endfunction

    task automatic model_edge(input bit r, t, i, o, a, e, p);
        if (r) begin
            m_phase = "IDLE";
            m_left  = 0;
            return;
        end
        if (((m_phase == "EVAC") || (m_phase == "PRESS")) && (i || o)) begin
            m_phase = "FAULT";
            return;
        end
        if (((m_phase == "OUTER_WAIT") || (m_phase == "DOCKED") || (m_phase == "WAIT_PRESS")) && i)
        begin
            m_phase = "FAULT";
            return;
        end
        case (m_phase)
            "IDLE":       if (a && !i && !o) begin m_phase = "ANNOUNCE"; m_left = AnnN; end
            "WAIT_EVAC":  if (e && !i && !o) begin m_phase = "EVAC"; m_left = EvacN; end
            "OUTER_WAIT": if (o) m_phase = "DOCKED";
            "DOCKED":     if (!o && !a) m_phase = "WAIT_PRESS";
            "WAIT_PRESS": if (o) m_phase = "DOCKED";
                          else if (p) begin m_phase = "PRESS"; m_left = PressN; end
            "INNER_WAIT": if (i) m_phase = "INNER_EXIT";
            "INNER_EXIT": if (!i) m_phase = "IDLE";
            "ANNOUNCE", "EVAC", "PRESS": begin
                if (t) m_left--;
                if (m_left == 0) begin
                    if (m_phase == "ANNOUNCE")  m_phase = "WAIT_EVAC";
                    else if (m_phase == "EVAC") m_phase = "OUTER_WAIT";
                    else                        m_phase = "INNER_WAIT";
                end
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs ahead of the next rising edge and queue the expected result.
    task automatic step(input bit r, t, i, o, a, e, p);
        @(negedge clock);
        rst               = r;
        bus.tick          = t;
        bus.innerPort     = i;
        bus.outerPort     = o;
        bus.arriving      = a;
        bus.evac          = e;
        bus.pressurize    = p;
        model_edge(r, t, i, o, a, e, p);
        exp_q.push_back(expected_of(m_phase));
    endtask

    task automatic idle_to_wait_press();
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        repeat (EvacN) step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: DUT outputs are stable #1 after every rising edge.
    initial begin
        exp_t want, got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{bus.display, bus.outerUnlock, bus.innerUnlock, bus.busy, bus.fault};
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL outputs at %0t: got disp=%b ou=%b iu=%b busy=%b fault=%b, want disp=%b ou=%b iu=%b busy=%b fault=%b",
                             $time, got.display, got.ou, got.iu, got.busy, got.fault,
                             want.display, want.ou, want.iu, want.busy, want.fault);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        bus.tick = 0; bus.innerPort = 0; bus.outerPort = 0;
        bus.arriving = 0; bus.evac = 0; bus.pressurize = 0;

        // Full arrival with defaults, including stray commands that must be ignored.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        idle_to_wait_press();
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (PressN) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Tick on the EVAC entry edge is not counted.
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // outerPort on the final PRESS tick faults; FAULT absorbs inputs until reset.
        step(1, 0, 0, 0, 0, 0, 0);
        idle_to_wait_press();
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (PressN - 1) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 0, 0);

        // Inner door open blocks the arrival; evac in DOCKED does nothing.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        repeat (EvacN) step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);

        // Reset in the middle of EVAC, then a fresh sequence timed from zero.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        idle_to_wait_press();

        // Outer door reopened in WAIT_PRESS returns to DOCKED; pressurize ignored meanwhile.
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (PressN) step(0, 1, 0, 0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clock);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
